// File: rtl/bo_datapath_if.sv
// Control-word / result bundle between the control FSM (master) and the BO datapath (slave).
// dbg_x and dbg_h expose the internal X and H registers for observation.
interface bo_datapath_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  // Control word from the FSM, already registered upstream
  logic [WIDTH-1:0] x_in;
  logic             LX;
  logic             LS;
  logic             LH;
  logic             Hula;
  logic [1:0]       M0;
  logic [1:0]       M1;
  logic [1:0]       M2;
  logic             clr_ovf;

  // result_valid is a one-cycle strobe with no ready: the consumer must take
  // result in the cycle result_valid is high; there is no back-pressure.
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             ovf;
  logic [CNT_W-1:0] sample_cnt;

  logic [WIDTH-1:0] dbg_x;
  logic [WIDTH-1:0] dbg_h;

  modport master (
    output x_in, LX, LS, LH, Hula, M0, M1, M2, clr_ovf,
    input  result, result_valid, ovf, sample_cnt, dbg_x, dbg_h
  );

  modport slave (
    input  x_in, LX, LS, LH, Hula, M0, M1, M2, clr_ovf,
    output result, result_valid, ovf, sample_cnt, dbg_x, dbg_h
  );
endinterface

// File: rtl/bo_datapath.sv
// BO operative datapath: X/H/S registers, add/multiply ALU, operand and write-back muxes.
// Optional macro BO_SAT_EN saturates the ALU result to all-ones on overflow.
module bo_datapath #(
  parameter int WIDTH = 16,
  parameter int K_A   = 1,
  parameter int K_B   = 2,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  bo_datapath_if.slave  bus
);

  localparam logic [WIDTH-1:0] KA_W = WIDTH'(K_A);
  localparam logic [WIDTH-1:0] KB_W = WIDTH'(K_B);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH:0]     add_full;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   alu_raw;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;
  logic [WIDTH-1:0]   wb;
  logic               ovf_set;
  logic               ovf_clr;

  // Operand muxes: every select code decodes, so no control word yields X
  always_comb begin
    op_a = x_q;
    unique case (bus.M0)
      2'd0:    op_a = x_q;
      2'd1:    op_a = h_q;
      2'd2:    op_a = s_q;
      default: op_a = KA_W;
    endcase
  end

  always_comb begin
    op_b = x_q;
    unique case (bus.M1)
      2'd0:    op_b = x_q;
      2'd1:    op_b = h_q;
      2'd2:    op_b = s_q;
      default: op_b = KB_W;
    endcase
  end

  always_comb begin
    add_full = {1'b0, op_a} + {1'b0, op_b};
    mul_full = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    if (bus.Hula) begin
      alu_raw = mul_full[WIDTH-1:0];
      alu_ov  = |mul_full[2*WIDTH-1:WIDTH];
    end else begin
      alu_raw = add_full[WIDTH-1:0];
      alu_ov  = add_full[WIDTH];
    end
  end

`ifdef BO_SAT_EN
  assign alu_res = alu_ov ? {WIDTH{1'b1}} : alu_raw;
`else
  assign alu_res = alu_raw;
`endif

  // Write-back bus; M2=3 shifts the already-truncated (or saturated) result
  always_comb begin
    wb = alu_res;
    unique case (bus.M2)
      2'd0:    wb = alu_res;
      2'd1:    wb = x_q;
      2'd2:    wb = op_a;
      default: wb = {1'b0, alu_res[WIDTH-1:1]};
    endcase
  end

  // Overflow only counts when the ALU result actually reaches a register
  always_comb begin
    ovf_set = alu_ov && (bus.LH || bus.LS) && ((bus.M2 == 2'd0) || (bus.M2 == 2'd3));
    ovf_clr = bus.clr_ovf || bus.LX;
    ovf_d   = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    x_d     = bus.LX ? bus.x_in : x_q;
    h_d     = bus.LH ? wb : h_q;
    s_d     = bus.LS ? wb : s_q;
    valid_d = bus.LS;
    cnt_d   = bus.LX ? (cnt_q + CNT_ONE) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      h_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_d;
      h_q     <= h_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.result       = s_q;
  assign bus.result_valid = valid_q;
  assign bus.ovf          = ovf_q;
  assign bus.sample_cnt   = cnt_q;
  assign bus.dbg_x        = x_q;
  assign bus.dbg_h        = h_q;

endmodule
